// File: rtl/comm_pkg.sv
// Shared types and constants for the UART command link: frame FSM states,
// command opcodes and the acknowledge byte.
package comm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } frame_state_t;

    localparam logic [7:0] REQ_BATT  = 8'h01;
    localparam logic [7:0] SET_PTCH  = 8'h02;
    localparam logic [7:0] SET_ROLL  = 8'h03;
    localparam logic [7:0] SET_YAW   = 8'h04;
    localparam logic [7:0] SET_THRST = 8'h05;
    localparam logic [7:0] CALIBRATE = 8'h06;
    localparam logic [7:0] EMER_LAND = 8'h07;
    localparam logic [7:0] MTRS_OFF  = 8'h08;

    localparam logic [7:0] ACK = 8'hA5;

endpackage

// File: rtl/uart_cmd_wrapper_if.sv
// Host-side bus of the command wrapper: decoded frame out, response byte in.
interface uart_cmd_wrapper_if;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        resp_sent;
    logic        tx_busy;

    modport master (
        input  cmd, data, cmd_rdy, resp_sent, tx_busy,
        output clr_cmd_rdy, send_resp, resp
    );

    modport slave (
        output cmd, data, cmd_rdy, resp_sent, tx_busy,
        input  clr_cmd_rdy, send_resp, resp
    );
endinterface

// File: rtl/uart_trcvr.sv
// 8N1 byte transceiver: independent receiver (synchronized, mid-bit sampling)
// and transmitter. rx_busy exists only when UART_CMD_FRAME_TIMEOUT_EN is defined.
module uart_trcvr #(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       tx,
    output logic       rx_rdy,
    output logic [7:0] rx_data,
`ifdef UART_CMD_FRAME_TIMEOUT_EN
    output logic       rx_busy,
`endif
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

    logic             rx_s1, rx_s2, rx_prev;
    logic             rx_act;
    logic [CNT_W-1:0] rx_cnt;
    logic [3:0]       rx_bit;
    logic [7:0]       rx_shift;

    logic [9:0]       tx_shift;
    logic [CNT_W-1:0] tx_cnt;
    logic [3:0]       tx_bit;

    // Receiver: bit 0 is the start bit, 1..8 data (LSB first), 9 the stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_act   <= 1'b0;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_rdy   <= 1'b0;
            rx_data  <= '0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            rx_rdy  <= 1'b0;
            if (!rx_act) begin
                if (rx_prev && !rx_s2) begin
                    rx_act <= 1'b1;
                    rx_cnt <= HALF_LAST;
                    rx_bit <= '0;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - CNT_W'(1);
            end else begin
                rx_cnt <= BIT_LAST;
                rx_bit <= rx_bit + 4'd1;
                if (rx_bit == 4'd0) begin
                    if (rx_s2) rx_act <= 1'b0;   // glitch, not a real start bit
                end else if (rx_bit < 4'd9) begin
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                end else begin
                    rx_act <= 1'b0;
                    if (rx_s2) begin
                        rx_rdy  <= 1'b1;
                        rx_data <= rx_shift;
                    end
                end
            end
        end
    end

`ifdef UART_CMD_FRAME_TIMEOUT_EN
    assign rx_busy = rx_act;
`endif

    // Transmitter: the shift register idles all-ones so the line idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift <= '1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (!tx_busy) begin
                if (trmt) begin
                    tx_shift <= {1'b1, tx_data, 1'b0};
                    tx_cnt   <= BIT_LAST;
                    tx_bit   <= '0;
                    tx_busy  <= 1'b1;
                end
            end else if (tx_cnt != '0) begin
                tx_cnt <= tx_cnt - CNT_W'(1);
            end else begin
                tx_cnt   <= BIT_LAST;
                tx_shift <= {1'b1, tx_shift[9:1]};
                if (tx_bit == 4'd9) begin
                    tx_busy <= 1'b0;
                    tx_done <= 1'b1;
                end else begin
                    tx_bit <= tx_bit + 4'd1;
                end
            end
        end
    end

    assign tx = tx_shift[0];

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Three-byte command frame decoder and response sender over a UART link.
// Define UART_CMD_FRAME_TIMEOUT_EN to abandon partial frames after an idle RX line.
module uart_cmd_wrapper
    import comm_pkg::*;
#(
    parameter int unsigned BAUD_DIV     = 2604,
    parameter int unsigned TIMEOUT_BITS = 40
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                RX,
    output logic                TX,
    uart_cmd_wrapper_if.slave   bus
);

    if (BAUD_DIV < 4 || TIMEOUT_BITS == 0) begin : g_bad_cfg
        $error("uart_cmd_wrapper: BAUD_DIV must be >= 4 and TIMEOUT_BITS nonzero");
    end

    frame_state_t state, state_nxt;
    logic         rx_rdy;
    logic [7:0]   rx_data;
    logic         ld_cmd_c, ld_hi_c, ld_lo_c;
    logic [7:0]   cmd_shadow, hi_shadow;
    logic         tx_busy, tx_done;

`ifdef UART_CMD_FRAME_TIMEOUT_EN
    localparam int unsigned TO_CLKS = TIMEOUT_BITS * BAUD_DIV;
    localparam int unsigned TO_W    = $clog2(TO_CLKS + 1);

    logic            rx_busy;
    logic [TO_W-1:0] to_cnt;
    logic            timeout_c;

    // Idle time on RX while a frame is partially received.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          to_cnt <= '0;
        else if (state == IDLE || rx_busy)   to_cnt <= '0;
        else if (!timeout_c)                 to_cnt <= to_cnt + TO_W'(1);
    end

    assign timeout_c = (to_cnt == TO_W'(TO_CLKS - 1));
`endif

    uart_trcvr #(.BAUD_DIV(BAUD_DIV)) u_trcvr (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (RX),
        .tx      (TX),
        .rx_rdy  (rx_rdy),
        .rx_data (rx_data),
`ifdef UART_CMD_FRAME_TIMEOUT_EN
        .rx_busy (rx_busy),
`endif
        .trmt    (bus.send_resp),
        .tx_data (bus.resp),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    assign bus.tx_busy   = tx_busy;
    assign bus.resp_sent = tx_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (rx_rdy) begin
            case (state)
                IDLE:    state_nxt = WAIT_HI;
                WAIT_HI: state_nxt = WAIT_LO;
                WAIT_LO: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
`ifdef UART_CMD_FRAME_TIMEOUT_EN
        else if (timeout_c) begin
            state_nxt = IDLE;
        end
`endif
    end

    always_comb begin
        ld_cmd_c = 1'b0;
        ld_hi_c  = 1'b0;
        ld_lo_c  = 1'b0;
        if (rx_rdy) begin
            ld_cmd_c = (state == IDLE);
            ld_hi_c  = (state == WAIT_HI);
            ld_lo_c  = (state == WAIT_LO);
        end
    end

    // Shadow bytes are only published when the whole frame has arrived.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_shadow  <= '0;
            hi_shadow   <= '0;
            bus.cmd     <= '0;
            bus.data    <= '0;
            bus.cmd_rdy <= 1'b0;
        end else begin
            if (ld_cmd_c) cmd_shadow <= rx_data;
            if (ld_hi_c)  hi_shadow  <= rx_data;
            if (ld_lo_c) begin
                bus.cmd     <= cmd_shadow;
                bus.data    <= {hi_shadow, rx_data};
                bus.cmd_rdy <= 1'b1;
            end else if (bus.clr_cmd_rdy || ld_cmd_c) begin
                bus.cmd_rdy <= 1'b0;
            end
        end
    end

endmodule
